// File: rtl/wb_host_bridge.sv
// Wishbone B4 classic single-transfer initiator for the core data port.
// One transfer in flight; a bounded wait turns a silent slave into an error.
module wb_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic bus_tmo;
  logic bus_done;

  // Compared before incrementing, so the counter never wraps.
  assign bus_tmo  = TO_EN && (cnt_q == CNT_LAST);
  assign bus_done = wbm_err_i | wbm_ack_i | bus_tmo;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i) state_d = BUS;
      BUS:     if (bus_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          cyc_d = 1'b1;
          we_d  = we_i;
          adr_d = addr_i;
          dat_d = wdata_i;
          sel_d = be_i;
          cnt_d = '0;
        end
      end
      BUS: begin
        if (bus_done) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          // Slave error beats ack; a bare timeout is also an error.
          err_d    = wbm_err_i | (~wbm_ack_i & bus_tmo);
          rdata_d  = (wbm_ack_i & ~wbm_err_i & ~we_q) ? wbm_dat_i : '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt_o     = (state_q == IDLE);
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: doc/wb_host_bridge.md
# wb_host_bridge

Wishbone classic single-transfer initiator that turns a simple core-side request/grant bus into Wishbone B4 classic cycles toward user-area peripherals (GPIO, UART wrapper, etc.). It sits between the RVJ1 core's data port and the user-area Wishbone interconnect. It holds one transaction outstanding at a time. A bounded timeout counter converts a hung or non-responding slave into an error response instead of a core stall.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `wbm_stb_o` is held without `wbm_ack_i`/`wbm_err_i`. 0 disables the timeout.
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `req_i` in 1: core request valid.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address, forwarded unmodified.
- `wdata_i` in 32: write data.
- `be_i` in 4: byte enables, forwarded as `wbm_sel_o`.
- `gnt_o` out 1: request accepted this cycle (combinational, `state==IDLE`).
- `rvalid_o` out 1: one-cycle response strobe.
- `rdata_o` out 32: read data, valid with `rvalid_o`.
- `err_o` out 1: bus error or timeout, valid with `rvalid_o`.
- `wbm_cyc_o`, `wbm_stb_o` out 1: Wishbone cycle/strobe (registered, always equal).
- `wbm_we_o` out 1: write enable.
- `wbm_adr_o` out 32: address.
- `wbm_dat_o` out 32: write data.
- `wbm_sel_o` out 4: byte select.
- `wbm_ack_i` in 1: slave acknowledge.
- `wbm_err_i` in 1: slave error; tie 0 if the slave has none.
- `wbm_dat_i` in 32: slave read data.

## Operation
- **FSM states:** IDLE, BUS, RESP.
- **IDLE:**
  - `gnt_o=1`.
  - On `req_i`: capture `we_i`/`addr_i`/`wdata_i`/`be_i` into the `wbm_*` output registers.
  - Set `cyc`/`stb`, clear the timeout counter, go to BUS.
- **BUS:**
  - `cyc`/`stb` high; `adr`/`dat`/`sel`/`we` held stable.
  - `gnt_o=0`; `req_i` is ignored.
  - `wbm_err_i`: capture error, go to RESP.
  - Else `wbm_ack_i`: capture `wbm_dat_i` if read (0 if write), go to RESP.
  - `ack` and `err` in the same cycle: error wins, `rdata=0`.
  - Else if `TIMEOUT_CYCLES!=0` and `count==TIMEOUT_CYCLES-1`: timeout error, go to RESP.
  - Else `count+1`.
  - `cyc`/`stb` are cleared on the BUS→RESP edge.
- **RESP:**
  - `rvalid_o=1` for exactly one cycle with the captured `rdata_o`/`err_o`.
  - Return to IDLE.
- **Counter width:** `max(1, $clog2(TIMEOUT_CYCLES+1))`. It never wraps, because it is compared before incrementing.
- **Error responses:** `rdata_o=0` whenever `err_o=1` and for all writes.
- **Stale inputs:** `wbm_ack_i`/`wbm_err_i` seen in IDLE or RESP are ignored; no state change, no response.
- **Reset (`rst_ni=0`, asynchronous):**
  - State goes to IDLE; counter cleared.
  - All outputs go to 0 immediately: `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o`, `rvalid_o`, `rdata_o`, `err_o`.
  - `gnt_o=1` once the state is IDLE.
  - A transaction in progress is dropped silently; no `rvalid_o` is issued for it after release.
- **Between responses:** `rdata_o`/`err_o` hold their last value; they are only meaningful while `rvalid_o=1`.

## Timing
- **Accept:** `req_i&&gnt_o` sampled at edge N; `wbm_cyc_o`/`wbm_stb_o` high from N+1.
- **Completion:** ack first sampled high at edge N+k (k≥1); `rvalid_o` high during N+k..N+k+1; `cyc`/`stb` low from N+k.
- **Fastest slave** (combinational ack, k=1): `rvalid_o` in the cycle after `stb`. Next `gnt_o` at N+2, i.e. one transfer every 3 cycles.
- **Registered-ack slave** (k=2): 4-cycle turnaround.
- **Timeout:** `stb` is held exactly `TIMEOUT_CYCLES` cycles, then `rvalid_o`+`err_o`. Default: 255 cycles of `stb`, response in cycle 256.
- **Back-to-back:** `req_i` held high through RESP is accepted on the first IDLE cycle, with no extra bubble.

## Test plan
- **Write, registered-ack slave:** `req` write, `addr=0x3001_0000`, `wdata=0x00A5_5A5A`, `be=0xF`.
  - `cyc`/`stb` high for 2 cycles with those exact values.
  - Then `rvalid=1`, `err=0`, `rdata=0`.
- **Read, zero-wait slave** returning `0x0012_3456`:
  - `stb` high exactly 1 cycle.
  - `rvalid` next cycle with `rdata=0x0012_3456`, `err=0`.
- **Timeout:** `TIMEOUT_CYCLES=4`, slave never acks a read of `0x3001_0001`.
  - `stb` high exactly 4 cycles, then `rvalid=1`, `err=1`, `rdata=0`.
  - `TIMEOUT_CYCLES=0` with the same slave: `stb` still high after 1000 cycles.
- **Error precedence:** `ack` and `err` high in the same BUS cycle → `err_o=1`, `rdata=0`. A spurious `ack` pulse in IDLE → no `rvalid`, state unchanged.
- **Async reset mid-BUS:** drop `rst_ni` 2 cycles into a 10-cycle-wait read.
  - `cyc`/`stb`/`rvalid` go to 0 within the same cycle, without a clock edge.
  - After release: `gnt_o=1` and no `rvalid` ever appears for the dropped read.
- **Back-to-back:** `req_i` held high for write then read with a zero-wait slave → `gnt_o` pulses at 3-cycle spacing, two `rvalid` pulses, second carrying the read data.
